// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton reader: FSM state encoding and the
// millisecond-to-clock-cycle conversion used to size the debounce and
// long-press intervals.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Divide first so large clock rates do not overflow a 32-bit int.
  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_reader_if.sv
// Button interface: raw button level in, debounced level and event strobes out.
// Ports: btn (raw level), pressed, press_pulse, release_pulse, long_pulse, toggle.
// master = the reader that produces the events, slave = the consumer of them.
interface button_reader_if;
  import button_pkg::*;

  logic btn;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic toggle;

  modport master (
    input  btn,
    output pressed, press_pulse, release_pulse, long_pulse, toggle
  );

  modport slave (
    output btn,
    input  pressed, press_pulse, release_pulse, long_pulse, toggle
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
// RST_VAL is the level both flops take on reset.
module sync_2ff
  import button_pkg::*;
#(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader with press/release/long-press strobes and an LED toggle.
// Ports: clk, rst (sync, active-high), bus (button_reader_if.master: btn in, events out).
// Optional macro LONG_PRESS_EN builds the long-press counter; otherwise long_pulse is 0.
module button_reader
  import button_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  button_reader_if.master bus
);

  // DEB_COUNT must be >= 1 and LONG_COUNT must exceed it.
  localparam int DEB_COUNT  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int LONG_COUNT = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int CW         = $clog2(LONG_COUNT + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_COUNT - 1);

  logic raw_sync;
  logic s;

  // Flops reset to the released raw level so reset never looks like a press.
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (raw_sync)
  );

  assign s = raw_sync ^ ACTIVE_LOW;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            press_nxt, release_nxt, pressed_nxt;
  logic            pressed_q, press_q, release_q, toggle_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  // Outputs are registered from the transition, so pressed and the strobes
  // change together, one edge after the FSM decides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pressed_q <= pressed_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
      toggle_q  <= toggle_q ^ press_nxt;
    end
  end

  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.toggle        = toggle_q;

`ifdef LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNT - 1);

  logic [CW-1:0] lcnt, lcnt_nxt;
  logic          long_done, long_done_nxt;
  logic          long_nxt, long_q;

  // Counter survives bounces back from RELEASE_WAIT; long_done keeps the
  // strobe to one per accepted press.
  always_comb begin
    lcnt_nxt      = lcnt;
    long_done_nxt = long_done;
    long_nxt      = 1'b0;
    if (press_nxt) begin
      lcnt_nxt      = '0;
      long_done_nxt = 1'b0;
    end else if (state == PRESSED && s && lcnt != LONG_LAST) begin
      lcnt_nxt = lcnt + 1'b1;
    end
    if (state == PRESSED && lcnt == LONG_LAST && !long_done) begin
      long_nxt      = 1'b1;
      long_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt      <= '0;
      long_done <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      lcnt      <= lcnt_nxt;
      long_done <= long_done_nxt;
      long_q    <= long_nxt;
    end
  end

  assign bus.long_pulse = long_q;
`else
  assign bus.long_pulse = 1'b0;
`endif

endmodule
